// File: rtl/com_stim_pkg.sv
// Shared types for the centre-of-mass stimulus generator: motion modes and the
// waypoint record used by the default 1280x720 geometry.
package com_stim_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_HOLD  = 2'd1,
    MODE_SWEEP = 2'd2,
    MODE_PATH  = 2'd3
  } com_mode_t;

  localparam int DEF_H_WIDTH = 11;
  localparam int DEF_V_WIDTH = 10;

  typedef struct packed {
    logic [DEF_H_WIDTH-1:0] x;
    logic [DEF_V_WIDTH-1:0] y;
  } waypoint_t;

endpackage

// File: rtl/period_timer.sv
// Free-running period counter: asserts tick on the last count of each period,
// advancing only while enabled.
module period_timer #(
  parameter int PERIOD = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic enable_in,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] count;

  assign tick = enable_in && (count == LAST);

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      count <= '0;
    end else if (enable_in) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/com_stimulus_gen.sv
// Simulated camera centre-of-mass source: one sample per timer tick in HOLD,
// SWEEP (edge-bouncing) or PATH (waypoint loop) mode, behind a valid/ready handshake.
module com_stimulus_gen
  import com_stim_pkg::*;
#(
  parameter int H_WIDTH    = 11,
  parameter int V_WIDTH    = 10,
  parameter int H_MAX      = 1279,
  parameter int V_MAX      = 719,
  parameter int X_START    = 200,
  parameter int Y_START    = 240,
  parameter int PERIOD     = 1_000_000,
  parameter int STEP_W     = 4,
  parameter int PATH_DEPTH = 8
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic [1:0]                    mode_in,
  input  logic [STEP_W-1:0]             x_step_in,
  input  logic [STEP_W-1:0]             y_step_in,
  input  logic                          wp_we_in,
  input  logic [$clog2(PATH_DEPTH)-1:0] wp_addr_in,
  input  logic [H_WIDTH-1:0]            wp_x_in,
  input  logic [V_WIDTH-1:0]            wp_y_in,
  input  logic [$clog2(PATH_DEPTH):0]   wp_count_in,
  input  logic                          com_ready_in,
  output logic                          new_com,
  output logic                          light_on,
  output logic [H_WIDTH-1:0]            x_com,
  output logic [V_WIDTH-1:0]            y_com,
  output logic                          overrun
);

  localparam int AW = $clog2(PATH_DEPTH);
  localparam int SW = ((H_WIDTH > V_WIDTH) ? H_WIDTH : V_WIDTH) + 2;
  localparam logic [AW:0]             DEPTH_L = (AW + 1)'(PATH_DEPTH);
  localparam logic signed [SW-1:0]    X_LIM   = SW'(H_MAX);
  localparam logic signed [SW-1:0]    Y_LIM   = SW'(V_MAX);

  function automatic logic signed [SW-1:0] step_pos(
    input logic signed [SW-1:0] pos,
    input logic [STEP_W-1:0]    step,
    input logic                 dir_neg
  );
    logic signed [SW-1:0] d;
    d = signed'(SW'(step));
    return dir_neg ? pos - d : pos + d;
  endfunction

  function automatic logic signed [SW-1:0] sat_pos(
    input logic signed [SW-1:0] pos,
    input logic signed [SW-1:0] lim
  );
    if (pos > lim) return lim;
    if (pos[SW-1]) return '0;
    return pos;
  endfunction

  function automatic logic out_of_range(
    input logic signed [SW-1:0] pos,
    input logic signed [SW-1:0] lim
  );
    return (pos > lim) || pos[SW-1];
  endfunction

  logic tick;

  period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .enable_in (enable_in),
    .tick      (tick)
  );

  logic [H_WIDTH-1:0] wp_x_mem [PATH_DEPTH];
  logic [V_WIDTH-1:0] wp_y_mem [PATH_DEPTH];

  logic          dir_x_neg, dir_y_neg;
  logic [AW-1:0] wp_idx;

  com_mode_t            mode_p0;
  logic                 stall_p0, xfer_p0, accept_p0, path_live_p0;
  logic [AW-1:0]        rd_idx_p0, nxt_idx_p0;
  logic signed [SW-1:0] x_raw_p0, y_raw_p0, x_sat_p0, y_sat_p0;
  logic                 x_flip_p0, y_flip_p0;

  // Stage p0: decide what the current tick does and precompute every candidate position
  always_comb begin
    mode_p0      = com_mode_t'(mode_in);
    stall_p0     = new_com & ~com_ready_in;
    xfer_p0      = new_com & com_ready_in;
    accept_p0    = tick & ~stall_p0;
    path_live_p0 = (mode_p0 == MODE_PATH) && (wp_count_in != '0);
    rd_idx_p0    = ({1'b0, wp_idx} >= wp_count_in) ? '0 : wp_idx;
    nxt_idx_p0   = (({1'b0, rd_idx_p0} + 1'b1) == wp_count_in) ? '0 : rd_idx_p0 + 1'b1;
    x_raw_p0     = step_pos(signed'(SW'(x_com)), x_step_in, dir_x_neg);
    y_raw_p0     = step_pos(signed'(SW'(y_com)), y_step_in, dir_y_neg);
    x_sat_p0     = sat_pos(x_raw_p0, X_LIM);
    y_sat_p0     = sat_pos(y_raw_p0, Y_LIM);
    x_flip_p0    = out_of_range(x_raw_p0, X_LIM);
    y_flip_p0    = out_of_range(y_raw_p0, Y_LIM);
  end

  // Stage p1: registered sample, handshake and motion state
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      new_com   <= 1'b0;
      light_on  <= 1'b0;
      x_com     <= H_WIDTH'(X_START);
      y_com     <= V_WIDTH'(Y_START);
      overrun   <= 1'b0;
      dir_x_neg <= 1'b0;
      dir_y_neg <= 1'b0;
      wp_idx    <= '0;
    end else begin
      if (tick && stall_p0) overrun <= 1'b1;
      if (accept_p0) begin
        case (mode_p0)
          MODE_OFF: begin
            light_on <= 1'b0;
            new_com  <= 1'b0;
            wp_idx   <= '0;
          end
          MODE_HOLD: begin
            light_on <= 1'b1;
            new_com  <= 1'b1;
            wp_idx   <= '0;
          end
          MODE_SWEEP: begin
            x_com     <= H_WIDTH'(x_sat_p0);
            y_com     <= V_WIDTH'(y_sat_p0);
            dir_x_neg <= dir_x_neg ^ x_flip_p0;
            dir_y_neg <= dir_y_neg ^ y_flip_p0;
            light_on  <= 1'b1;
            new_com   <= 1'b1;
            wp_idx    <= '0;
          end
          MODE_PATH: begin
            // An empty table degenerates to HOLD
            if (path_live_p0) begin
              x_com  <= wp_x_mem[rd_idx_p0];
              y_com  <= wp_y_mem[rd_idx_p0];
              wp_idx <= nxt_idx_p0;
            end else begin
              wp_idx <= '0;
            end
            light_on <= 1'b1;
            new_com  <= 1'b1;
          end
          default: ;
        endcase
      end else if (xfer_p0) begin
        new_com <= 1'b0;
      end
    end
  end

  // Table is plain storage; a same-cycle read sees the previous contents
  always_ff @(posedge clk_in) begin
    if (wp_we_in && ({1'b0, wp_addr_in} < DEPTH_L)) begin
      wp_x_mem[wp_addr_in] <= wp_x_in;
      wp_y_mem[wp_addr_in] <= wp_y_in;
    end
  end

endmodule

// File: tb/tb_com_stimulus_gen.sv
// Bench for com_stimulus_gen: directed scenarios then randomized traffic, all
// checked every cycle against a behavioural sample-stream model.
module tb_com_stimulus_gen;

  localparam int P     = 4;
  localparam int HMAX  = 1279;
  localparam int VMAX  = 719;
  localparam int DEPTH = 8;

  logic        clk_in = 1'b0;
  logic        rst_in, enable_in, wp_we_in, com_ready_in;
  logic [1:0]  mode_in;
  logic [3:0]  x_step_in, y_step_in, wp_count_in;
  logic [2:0]  wp_addr_in;
  logic [10:0] wp_x_in;
  logic [9:0]  wp_y_in;
  logic        new_com, light_on, overrun;
  logic [10:0] x_com;
  logic [9:0]  y_com;

  com_stimulus_gen #(.PERIOD(P)) dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .enable_in    (enable_in),
    .mode_in      (mode_in),
    .x_step_in    (x_step_in),
    .y_step_in    (y_step_in),
    .wp_we_in     (wp_we_in),
    .wp_addr_in   (wp_addr_in),
    .wp_x_in      (wp_x_in),
    .wp_y_in      (wp_y_in),
    .wp_count_in  (wp_count_in),
    .com_ready_in (com_ready_in),
    .new_com      (new_com),
    .light_on     (light_on),
    .x_com        (x_com),
    .y_com        (y_com),
    .overrun      (overrun)
  );

  always #5 clk_in = ~clk_in;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: counts enabled cycles, emits samples per the motion rules
  int m_cnt, m_x, m_y, m_dx, m_dy, m_idx;
  bit m_vld, m_light, m_ovr;
  int tab_x [DEPTH];
  int tab_y [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit tick, busy;
    int cnt, nx, ny;
    if (!rst_in) begin
      m_cnt = 0; m_x = 200; m_y = 240; m_dx = 1; m_dy = 1; m_idx = 0;
      m_vld = 0; m_light = 0; m_ovr = 0;
    end else begin
      tick = enable_in && (m_cnt == P - 1);
      busy = m_vld && !com_ready_in;
      if (enable_in) m_cnt = tick ? 0 : m_cnt + 1;
      if (tick && busy) begin
        m_ovr = 1;
      end else if (tick) begin
        cnt = int'(wp_count_in);
        if (mode_in == 2'd0) begin
          m_vld = 0; m_light = 0; m_idx = 0;
        end else if (mode_in == 2'd3 && cnt != 0) begin
          if (m_idx >= cnt) m_idx = 0;
          m_x = tab_x[m_idx];
          m_y = tab_y[m_idx];
          m_idx = (m_idx + 1 == cnt) ? 0 : m_idx + 1;
          m_vld = 1; m_light = 1;
        end else begin
          if (mode_in == 2'd2) begin
            nx = m_x + m_dx * int'(x_step_in);
            ny = m_y + m_dy * int'(y_step_in);
            if (nx > HMAX) begin nx = HMAX; m_dx = -m_dx; end
            else if (nx < 0) begin nx = 0; m_dx = -m_dx; end
            if (ny > VMAX) begin ny = VMAX; m_dy = -m_dy; end
            else if (ny < 0) begin ny = 0; m_dy = -m_dy; end
            m_x = nx; m_y = ny;
          end
          m_vld = 1; m_light = 1; m_idx = 0;
        end
      end else if (m_vld && com_ready_in) begin
        m_vld = 0;
      end
    end
    if (wp_we_in) begin
      tab_x[int'(wp_addr_in)] = int'(wp_x_in);
      tab_y[int'(wp_addr_in)] = int'(wp_y_in);
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk_in);
    #1;
    chk("new_com", new_com, m_vld);
    chk("light_on", light_on, m_light);
    chk("x_com", x_com, m_x);
    chk("y_com", y_com, m_y);
    chk("overrun", overrun, m_ovr);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  task automatic set_wp(input int a, input int x, input int y);
    wp_we_in   = 1'b1;
    wp_addr_in = 3'(a);
    wp_x_in    = 11'(x);
    wp_y_in    = 10'(y);
    cyc();
    wp_we_in   = 1'b0;
  endtask

  initial begin
    rst_in = 1'b0; enable_in = 1'b1; mode_in = 2'd1;
    x_step_in = '0; y_step_in = '0; wp_we_in = 1'b0; wp_addr_in = '0;
    wp_x_in = '0; wp_y_in = '0; wp_count_in = '0; com_ready_in = 1'b1;

    cycles(3);
    rst_in = 1'b1;
    cycles(12);

    for (int i = 0; i < DEPTH; i++) begin
      if (i < 3) set_wp(i, 10 + 20 * i, 20 + 20 * i);
      else       set_wp(i, int'($urandom_range(0, 2047)), int'($urandom_range(0, 1023)));
    end
    wp_count_in = 4'd3; mode_in = 2'd3;
    cycles(20);
    wp_count_in = 4'd0;
    cycles(8);

    // Right edge bounce from x=1270
    set_wp(0, 1270, 100);
    wp_count_in = 4'd1;
    cycles(4);
    mode_in = 2'd2; x_step_in = 4'd8;
    cycles(12);

    // Left edge bounce from x=3, now travelling -x
    mode_in = 2'd3;
    set_wp(0, 3, 100);
    cycles(4);
    mode_in = 2'd2;
    cycles(8);
    y_step_in = 4'd15;
    cycles(160);

    // Stall across ticks, then drain
    mode_in = 2'd1; x_step_in = '0; y_step_in = '0;
    com_ready_in = 1'b0;
    cycles(10);
    chk("overrun_set", overrun, 1);
    com_ready_in = 1'b1;
    cycles(8);

    // Reset while a sample is pending
    com_ready_in = 1'b0;
    cycles(5);
    rst_in = 1'b0;
    cyc();
    chk("rst_new_com", new_com, 0);
    chk("rst_x", x_com, 200);
    rst_in = 1'b1; com_ready_in = 1'b1;

    mode_in = 2'd0;
    cycles(12);
    chk("off_light", light_on, 0);
    enable_in = 1'b0; mode_in = 2'd1;
    cycles(6);
    enable_in = 1'b1;

    for (int i = 0; i < 800; i++) begin
      if (i % 16 == 0) begin
        mode_in     = 2'($urandom_range(0, 3));
        wp_count_in = 4'($urandom_range(0, DEPTH));
        x_step_in   = 4'($urandom);
        y_step_in   = 4'($urandom);
      end
      enable_in    = ($urandom % 8) != 0;
      com_ready_in = ($urandom % 4) != 0;
      wp_we_in     = ($urandom % 4) == 0;
      wp_addr_in   = 3'($urandom);
      wp_x_in      = 11'($urandom);
      wp_y_in      = 10'($urandom);
      rst_in       = ($urandom % 150) != 0;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
